// File: rtl/shift_align_pipe_if.sv
// Operand/result bundle for the pipelined alignment shifter.
// The master side presents operands and the stall enable; the slave side is the shifter.
interface shift_align_pipe_if #(
    parameter int W_Sgf = 23,
    parameter int W_Exp = 8
);
    localparam int W = W_Sgf + 3;

    logic             ena;
    logic             in_valid;
    logic             left_right;
    logic [W_Exp-1:0] nshift;
    logic [W-1:0]     sgfm;

    logic             out_valid;
    logic [W-1:0]     sgfm_n;
    logic             sticky;
    logic             zero;

    modport master (
        output ena, in_valid, left_right, nshift, sgfm,
        input  out_valid, sgfm_n, sticky, zero
    );

    modport slave (
        input  ena, in_valid, left_right, nshift, sgfm,
        output out_valid, sgfm_n, sticky, zero
    );
endinterface

// File: rtl/shift_align_pipe.sv
// Pipelined significand alignment shifter for the FP add/sub datapath.
// An input register followed by one registered log-shifter level per amount bit,
// giving a latency of $clog2(W)+1 enabled cycles. Right shifts collect a sticky bit
// from every discarded bit; amounts of W or more saturate the result to zero.
module shift_align_pipe #(
    parameter int W_Sgf = 23,
    parameter int W_Exp = 8
) (
    input logic               clk,
    input logic               rst,
    shift_align_pipe_if.slave bus
);
    localparam int W       = W_Sgf + 3;
    localparam int SH_BITS = $clog2(W);

    // Index 0 is the input register; index k+1 holds the result of level k.
    logic [W-1:0]       data_q [0:SH_BITS];
    logic [SH_BITS-1:0] amt_q  [0:SH_BITS-1];
    logic [SH_BITS-1:0] dir_q;
    logic [SH_BITS:0]   stk_q;
    logic [SH_BITS:0]   vld_q;
    logic               zero_q;

    logic               sat;
    logic [SH_BITS-1:0] in_amt;
    logic               in_stk;

    logic [W-1:0]       data_n [0:SH_BITS-1];
    logic [SH_BITS-1:0] stk_n;

    // Saturation detect and amount truncation; a narrow amount input can never reach W.
    generate
        if (W_Exp >= SH_BITS) begin : g_wide_amt
            localparam logic [W_Exp:0] SAT_LIM = (W_Exp + 1)'(W);
            assign sat    = ({1'b0, bus.nshift} >= SAT_LIM);
            assign in_amt = bus.nshift[SH_BITS-1:0];
        end else begin : g_narrow_amt
            assign sat    = 1'b0;
            assign in_amt = {{(SH_BITS - W_Exp){1'b0}}, bus.nshift};
        end
    endgenerate

    // A saturated right shift discards the whole operand, so its sticky is any set bit.
    always_comb begin
        in_stk = sat && !bus.left_right && (|bus.sgfm);
    end

    // Each level shifts by 2^k when its amount bit is set, folding dropped LSBs into sticky.
    always_comb begin
        for (int k = 0; k < SH_BITS; k++) begin
            data_n[k] = data_q[k];
            stk_n[k]  = stk_q[k];
            if (amt_q[k][k]) begin
                if (dir_q[k]) begin
                    data_n[k] = data_q[k] << (1 << k);
                end else begin
                    data_n[k] = data_q[k] >> (1 << k);
                    stk_n[k]  = stk_q[k] | (|(data_q[k] & ((W'(1) << (1 << k)) - W'(1))));
                end
            end
        end
    end

    // Pipeline registers advance together on ena and hold everything, valid included, when stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= SH_BITS; k++) begin
                data_q[k] <= '0;
            end
            for (int k = 0; k < SH_BITS; k++) begin
                amt_q[k] <= '0;
            end
            dir_q  <= '0;
            stk_q  <= '0;
            vld_q  <= '0;
            zero_q <= 1'b0;
        end else if (bus.ena) begin
            data_q[0] <= sat ? '0 : bus.sgfm;
            amt_q[0]  <= sat ? '0 : in_amt;
            for (int k = 0; k < SH_BITS; k++) begin
                data_q[k+1] <= data_n[k];
            end
            for (int k = 1; k < SH_BITS; k++) begin
                amt_q[k] <= amt_q[k-1];
            end
            dir_q  <= {dir_q[SH_BITS-2:0], bus.left_right};
            stk_q  <= {stk_n, in_stk};
            vld_q  <= {vld_q[SH_BITS-1:0], bus.in_valid};
            zero_q <= (data_n[SH_BITS-1] == '0);
        end
    end

    assign bus.out_valid = vld_q[SH_BITS];
    assign bus.sgfm_n    = data_q[SH_BITS];
    assign bus.sticky    = stk_q[SH_BITS];
    assign bus.zero      = zero_q;

endmodule
